// File: rtl/byte_decode.sv
// byte_decode: streaming ByteDecode_d unpacker for one Kyber polynomial.
// A little-endian packed byte stream is collected LSB-first into a small bit
// buffer and emitted as NCOEFF coefficients of d bits each (1 <= d <= 11).
// Coefficients are zero-extended to 11 bits so they can feed decompress
// directly, and the latched d is exported alongside them.
module byte_decode #(
  parameter int NCOEFF = 256,
  parameter int BUF_W  = 24
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_start,
  input  logic [3:0]  i_d,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  output logic        o_byte_ready,
  output logic [10:0] o_coeff,
  output logic        o_coeff_valid,
  input  logic        i_coeff_ready,
  output logic [7:0]  o_coeff_idx,
  output logic [3:0]  o_d,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  // Fill count spans 0..BUF_W inclusive.
  localparam int CNT_W = $clog2(BUF_W + 1);
  // Byte counter must reach NCOEFF*11/8 for the widest legal d.
  localparam int BIN_W = $clog2((NCOEFF / 8) * 11 + 1);
  // A byte may only enter while it still fits entirely in the buffer.
  localparam logic [CNT_W-1:0] CNT_BYTE_MAX = CNT_W'(BUF_W - 8);
  localparam logic [7:0]       LAST_IDX     = 8'(NCOEFF - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             state_reg;
  logic [BUF_W-1:0]   bit_buf_reg;
  logic [BUF_W-1:0]   bit_buf_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic [CNT_W-1:0]   cnt_next;
  logic [3:0]         d_reg;
  logic [BIN_W-1:0]   bytes_in_reg;
  logic [7:0]         coeffs_out_reg;
  logic               done_reg;
  logic               err_reg;

  logic               run;
  logic               start_legal;
  logic               byte_fire;
  logic               coeff_fire;
  logic               last_coeff;
  logic [CNT_W-1:0]   d_ext;
  logic [CNT_W-1:0]   ins_pos;
  logic [BIN_W-1:0]   byte_limit;
  logic [BUF_W-1:0]   shifted;
  logic [BUF_W-1:0]   byte_placed;

  assign run         = (state_reg == ST_RUN);
  assign start_legal = (i_d != 4'd0) && (i_d <= 4'd11);
  assign d_ext       = CNT_W'(d_reg);

  // A polynomial at width d occupies exactly NCOEFF*d/8 bytes; refuse any more.
  assign byte_limit  = BIN_W'(d_reg) * BIN_W'(NCOEFF / 8);

  // Flow control depends only on registered state, never on the partner's
  // valid/ready, so there is no combinational path through the block.
  assign o_byte_ready  = run && (cnt_reg <= CNT_BYTE_MAX) && (bytes_in_reg < byte_limit);
  assign o_coeff_valid = run && (cnt_reg >= d_ext);

  assign byte_fire  = i_byte_valid && o_byte_ready;
  assign coeff_fire = o_coeff_valid && i_coeff_ready;
  assign last_coeff = (coeffs_out_reg == LAST_IDX);

  assign o_coeff_idx = coeffs_out_reg;
  assign o_d         = d_reg;
  assign o_busy      = run;
  assign o_done      = done_reg;
  assign o_err       = err_reg;

  // The coefficient is the low d bits of the buffer; bits at or above d are
  // forced to zero so stale buffered bits never leak into the output.
  genvar gi;
  generate
    for (gi = 0; gi < 11; gi++) begin : g_coeff_bit
      assign o_coeff[gi] = (d_reg > 4'(gi)) ? bit_buf_reg[gi] : 1'b0;
    end
  endgenerate

  // Next buffer/fill: consume d bits from the bottom, then append the new byte
  // just above the bits that remain after that consumption.
  always_comb begin
    shifted      = bit_buf_reg;
    ins_pos      = cnt_reg;
    byte_placed  = '0;
    bit_buf_next = bit_buf_reg;
    cnt_next     = cnt_reg;

    if (coeff_fire) begin
      shifted = bit_buf_reg >> d_reg;
      ins_pos = cnt_reg - d_ext;
    end

    if (byte_fire) begin
      byte_placed = BUF_W'(i_byte) << ins_pos;
    end

    // Bits above cnt are always zero, so OR-ing in the byte is a clean insert.
    bit_buf_next = shifted | byte_placed;
    cnt_next     = cnt_reg
                 + (byte_fire  ? CNT_W'(8) : CNT_W'(0))
                 - (coeff_fire ? d_ext     : CNT_W'(0));
  end

  // Control FSM plus all datapath state; done/err are single-cycle pulses.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_reg      <= ST_IDLE;
      bit_buf_reg    <= '0;
      cnt_reg        <= '0;
      d_reg          <= '0;
      bytes_in_reg   <= '0;
      coeffs_out_reg <= '0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (i_start) begin
            if (start_legal) begin
              state_reg      <= ST_RUN;
              d_reg          <= i_d;
              bit_buf_reg    <= '0;
              cnt_reg        <= '0;
              bytes_in_reg   <= '0;
              coeffs_out_reg <= '0;
            end else begin
              // Illegal width: report it and leave every counter untouched.
              err_reg <= 1'b1;
            end
          end
        end

        ST_RUN: begin
          // i_start is deliberately ignored while a polynomial is in flight.
          bit_buf_reg <= bit_buf_next;
          cnt_reg     <= cnt_next;
          if (byte_fire) begin
            bytes_in_reg <= bytes_in_reg + BIN_W'(1);
          end
          if (coeff_fire) begin
            coeffs_out_reg <= coeffs_out_reg + 8'd1;
            // 256*d is a multiple of 8, so the buffer is empty right here.
            if (last_coeff) begin
              state_reg <= ST_IDLE;
              done_reg  <= 1'b1;
            end
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_decode.sv
// tb_byte_decode: randomized self-checking bench for byte_decode. Expected
// coefficients come from a bit-level reading of the packed byte stream.
module tb_byte_decode;

  logic        clk;
  logic        rstn;
  logic        i_start;
  logic [3:0]  i_d;
  logic [7:0]  i_byte;
  logic        i_byte_valid;
  logic        o_byte_ready;
  logic [10:0] o_coeff;
  logic        o_coeff_valid;
  logic        i_coeff_ready;
  logic [7:0]  o_coeff_idx;
  logic [3:0]  o_d;
  logic        o_busy;
  logic        o_done;
  logic        o_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] stream_q[$];

  byte_decode dut (
    .i_clk         (clk),
    .i_rstn        (rstn),
    .i_start       (i_start),
    .i_d           (i_d),
    .i_byte        (i_byte),
    .i_byte_valid  (i_byte_valid),
    .o_byte_ready  (o_byte_ready),
    .o_coeff       (o_coeff),
    .o_coeff_valid (o_coeff_valid),
    .i_coeff_ready (i_coeff_ready),
    .o_coeff_idx   (o_coeff_idx),
    .o_d           (o_d),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_err         (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Coefficient j is the d-bit little-endian number at stream bits j*d .. j*d+d-1.
  function automatic logic [10:0] ref_coeff(input int j, input int d);
    int v;
    v = 0;
    for (int k = 0; k < d; k++) begin
      int n;
      logic [7:0] b;
      n = j * d + k;
      b = stream_q[n / 8];
      if (b[n % 8]) v = v + (1 << k);
    end
    return 11'(v);
  endfunction

  task automatic fill_stream(input int d);
    stream_q.delete();
    for (int i = 0; i < 32 * d; i++) stream_q.push_back(8'($urandom_range(255, 0)));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(o_byte_ready), 32'd0);
    check({tag, "_cvalid"}, 32'(o_coeff_valid), 32'd0);
    check({tag, "_coeff"}, 32'(o_coeff), 32'd0);
    check({tag, "_idx"}, 32'(o_coeff_idx), 32'd0);
    check({tag, "_d"}, 32'(o_d), 32'd0);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_done"}, 32'(o_done), 32'd0);
    check({tag, "_err"}, 32'(o_err), 32'd0);
  endtask

  // Pulse i_start for one cycle; returns at the following negedge (cycle T+1).
  task automatic do_start(input int d);
    @(negedge clk);
    i_start = 1'b1;
    i_d     = 4'(d);
    @(negedge clk);
    i_start = 1'b0;
    i_d     = 4'd0;
  endtask

  task automatic illegal_start(input int d, input int prev_d, input string tag);
    do_start(d);
    check({tag, "_err_pulse"}, 32'(o_err), 32'd1);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_ready"}, 32'(o_byte_ready), 32'd0);
    check({tag, "_d_kept"}, 32'(o_d), 32'(prev_d));
    @(negedge clk);
    check({tag, "_err_end"}, 32'(o_err), 32'd0);
    $display("[TB] illegal start d=%0d err pulse observed=%0d", d, n_fail == 0);
  endtask

  // Decode one polynomial from stream_q. abort_at >= 0 resets the DUT when that
  // coefficient index is reached; restart_at >= 0 pulses i_start mid-run.
  task automatic run_poly(input string name, input int d, input int stall_pct,
                          input int abort_at, input int restart_at);
    int  bi;
    int  ci;
    int  cycles;
    bit  bv;
    bit  cr;
    bit  bf;
    bit  cf;
    bit  drop_checked;
    bit  restarted;
    bi = 0; ci = 0; cycles = 0; drop_checked = 0; restarted = 0;

    do_start(d);
    check({name, "_busy_t1"}, 32'(o_busy), 32'd1);
    check({name, "_ready_t1"}, 32'(o_byte_ready), 32'd1);
    check({name, "_d_latched"}, 32'(o_d), 32'(d));
    check({name, "_cvalid_t1"}, 32'(o_coeff_valid), 32'd0);

    while (ci < 256 && cycles < 4000) begin
      if (ci == abort_at) begin
        rstn = 1'b0;
        i_byte_valid  = 1'b0;
        i_coeff_ready = 1'b0;
        #1;
        check_all_zero({name, "_abort"});
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check({name, "_no_done"}, 32'(o_done), 32'd0);
          check({name, "_idle_after_abort"}, 32'(o_busy), 32'd0);
        end
        $display("[TB] poly %s d=%0d aborted at coeff %0d", name, d, ci);
        return;
      end

      if (ci == restart_at && !restarted) begin
        restarted = 1;
        i_start = 1'b1;
        i_d     = (d == 3) ? 4'd5 : 4'd3;
      end

      bv = (stall_pct == 0) || ($urandom_range(99, 0) >= stall_pct);
      cr = (stall_pct == 0) || ($urandom_range(99, 0) >= stall_pct);
      i_byte_valid  = bv;
      i_byte        = (bi < stream_q.size()) ? stream_q[bi] : 8'h00;
      i_coeff_ready = cr;

      if (bi == 32 * d && !drop_checked) begin
        drop_checked = 1;
        check({name, "_ready_drop"}, 32'(o_byte_ready), 32'd0);
      end
      if (o_coeff_valid) begin
        check({name, "_idx"}, 32'(o_coeff_idx), 32'(ci));
        check({name, "_coeff"}, 32'(o_coeff), 32'(ref_coeff(ci, d)));
      end

      bf = bv && o_byte_ready;
      cf = o_coeff_valid && cr;
      @(negedge clk);
      cycles++;
      i_start = 1'b0;
      i_d     = 4'd0;
      if (bf) bi++;
      if (cf) ci++;
      if (restarted && ci == restart_at + 1 && cf) begin
        check({name, "_d_after_restart"}, 32'(o_d), 32'(d));
      end
    end

    i_byte_valid  = 1'b0;
    i_coeff_ready = 1'b0;
    check({name, "_all_coeffs"}, 32'(ci), 32'd256);
    check({name, "_bytes_used"}, 32'(bi), 32'(32 * d));
    check({name, "_done_pulse"}, 32'(o_done), 32'd1);
    check({name, "_busy_end"}, 32'(o_busy), 32'd0);
    if (stall_pct == 0) begin
      check({name, "_cycle_bound"}, 32'(cycles + 1 <= 32 * d + 258), 32'd1);
    end
    @(negedge clk);
    check({name, "_done_one_cycle"}, 32'(o_done), 32'd0);
    $display("[TB] poly %s d=%0d stall=%0d bytes=%0d coeffs=%0d cycles=%0d",
             name, d, stall_pct, bi, ci, cycles);
  endtask

  initial begin
    int dsel[5];
    dsel = '{1, 4, 5, 10, 11};

    rstn          = 1'b0;
    i_start       = 1'b0;
    i_d           = 4'd0;
    i_byte        = 8'h00;
    i_byte_valid  = 1'b0;
    i_coeff_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rstn = 1'b1;
    @(negedge clk);

    // d=1 starting with 0xA5 -> 1,0,1,0,0,1,0,1
    fill_stream(1);
    stream_q[0] = 8'hA5;
    run_poly("d1_a5", 1, 0, -1, -1);

    // d=4 starting with 0x21 -> 1,2
    fill_stream(4);
    stream_q[0] = 8'h21;
    run_poly("d4_21", 4, 0, -1, -1);

    // d=10 with 0x01,0x08,0x30,0xC0,0xFF -> 0x001,0x002,0x003,0x3FF
    fill_stream(10);
    stream_q[0] = 8'h01;
    stream_q[1] = 8'h08;
    stream_q[2] = 8'h30;
    stream_q[3] = 8'hC0;
    stream_q[4] = 8'hFF;
    run_poly("d10_vec", 10, 30, -1, -1);

    // d=11 with eleven 0xFF bytes up front -> eight 0x7FF, stalled both sides
    fill_stream(11);
    for (int i = 0; i < 11; i++) stream_q[i] = 8'hFF;
    run_poly("d11_ff", 11, 40, -1, -1);

    illegal_start(12, 11, "ill12");
    illegal_start(0, 11, "ill0");

    // i_start during RUN must be ignored
    fill_stream(5);
    run_poly("d5_restart", 5, 20, -1, 50);

    for (int p = 0; p < 10; p++) begin
      int d;
      d = dsel[$urandom_range(4, 0)];
      fill_stream(d);
      run_poly($sformatf("rand%0d", p), d, int'($urandom_range(50, 0)), -1, -1);
    end

    // Reset at coefficient 100, then a clean decode from idx 0
    fill_stream(4);
    run_poly("d4_abort", 4, 25, 100, -1);
    fill_stream(10);
    run_poly("d10_after_abort", 10, 15, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/byte_decode.md
# byte_decode

Streaming ByteDecode_d unpacker for the Kyber datapath. It sits directly upstream of `decompress` and turns a little-endian packed byte stream (ciphertext u/v or a message) into 256 d-bit coefficients of one polynomial. Output coefficients are 11 bits wide so they drive `decompress.i_coeff` directly. The latched `d` is exported so it can drive `decompress.i_d`.

## Interface
- NCOEFF, 256: coefficients per polynomial.
- BUF_W, 24: bit-buffer width. Must be at least 8 + 11 + 5.
- i_clk  in  1  clock.
- i_rstn  in  1  reset. One clock; reset is asynchronous and active-low.
- i_start  in  1  one-cycle pulse that starts a polynomial. Sampled only in IDLE.
- i_d  in  4  bit width d, sampled with i_start. Legal range is 1..11.
- i_byte  in  8  packed input byte.
- i_byte_valid  in  1  input byte valid.
- o_byte_ready  out  1  input byte ready.
- o_coeff  out  11  decoded coefficient, zero-extended above bit d-1.
- o_coeff_valid  out  1  output coefficient valid.
- i_coeff_ready  in  1  downstream ready.
- o_coeff_idx  out  8  index 0..255 of the current o_coeff.
- o_d  out  4  latched d.
- o_busy  out  1  high in RUN.
- o_done  out  1  one-cycle pulse after the last coefficient is accepted.
- o_err  out  1  one-cycle pulse when a start carries an illegal d.

## Operation
- FSM states: IDLE and RUN.
  - IDLE → RUN: i_start with i_d in 1..11. On this transition d is latched and all counters and the buffer are cleared.
  - IDLE, i_start with i_d = 0 or i_d > 11: stay in IDLE, no counters change, pulse o_err.
  - i_start in RUN is ignored.
- Bit buffer `buf[BUF_W-1:0]` with fill count `cnt` (0..BUF_W). Bits are LSB-first, as in FIPS 203 ByteDecode: coefficient j = bits [j·d, j·d+d−1] of the stream, bit 0 of byte 0 first.
- o_byte_ready = RUN && (cnt ≤ BUF_W−8) && (bytes_in < 32·d).
- o_coeff_valid = RUN && (cnt ≥ d).
- o_coeff = buf[d−1:0], upper bits zero. o_coeff_idx = coeffs_out.
- Byte handshake (valid && ready): the byte is inserted at bit position cnt − (d if a coefficient handshake occurs in the same cycle, else 0). bytes_in increments.
- Coefficient handshake (valid && i_coeff_ready): buf shifts right by d and coeffs_out increments.
- Simultaneous handshakes: cnt_next = cnt + 8 − d. Both must be supported in one cycle.
- Termination: 256·d is a multiple of 8, so the last byte exactly fills the buffer and cnt = 0 after coefficient 255. On handshake of coefficient 255, the block returns to IDLE and o_done is asserted in the following cycle.
- No skid buffering: o_coeff is driven from the registered buffer and holds stable while valid && !ready.

## Timing
- Reset values: FSM = IDLE, cnt = 0, buf = 0, counters = 0, o_d = 0. All outputs are 0: o_byte_ready, o_coeff_valid, o_coeff, o_coeff_idx, o_busy, o_done, o_err.
- i_start in cycle T: o_busy and o_byte_ready are high in T+1. o_err pulses in T+1 for an illegal d.
- Byte accepted in cycle T makes cnt ≥ d: o_coeff_valid is high in T+1 (one cycle of latency).
- Throughput with continuous valid/ready:
  - d ≤ 8: limited by input, 8/d coefficients per byte.
  - d > 8: one coefficient per cycle while buffered bits last.
  - Full polynomial takes ≤ 32·d + 256 + 2 cycles.
- Coefficient 255 handshaken in cycle T: o_busy = 0 and o_done = 1 in T+1, o_done = 0 in T+2. A new i_start is accepted in T+1.
- Reset asserted mid-RUN: all state clears asynchronously. The partial polynomial is discarded and no o_done is issued.

## Test plan
- d = 1, one byte 0xA5 → coefficients 1,0,1,0,0,1,0,1 at idx 0..7. After 32 bytes and 256 coefficients, o_done pulses once.
- d = 4, byte 0x21 → coefficients 1, 2. The full polynomial consumes exactly 128 bytes, and o_byte_ready drops after byte 128.
- d = 10, bytes 0x01,0x08,0x30,0xC0,0xFF → coefficients 0x001, 0x002, 0x003, 0x3FF.
- d = 11, 11 bytes of 0xFF → 8 coefficients of 0x7FF. With random i_coeff_ready and i_byte_valid stalls, o_coeff stays stable under stall, and the stream matches a golden model feeding `decompress` for 10 random polynomials at d ∈ {1,4,5,10,11}.
- i_start with i_d = 12 → o_err pulses for one cycle, o_busy stays 0. i_start with i_d = 0 → same response. i_start during RUN → no effect on counters.
- Reset pulse at coefficient 100 → all outputs 0 immediately and no o_done. A subsequent i_start decodes the next polynomial correctly from idx 0.
